// File: rtl/alu_cmd_sequencer.sv
// Command FIFO + one-at-a-time issue stage for the 8-bit combinational ALU.
// Optional illegal-opcode trap: define ALU_SEQ_ILLEGAL_TRAP_EN.
module alu_cmd_sequencer #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [4:0]   cmd_sel,
  input  logic [W-1:0] cmd_a,
  input  logic [W-1:0] cmd_b,
  input  logic         cmd_use_acc,
  output logic [W-1:0] alu_a,
  output logic [W-1:0] alu_b,
  output logic [4:0]   alu_sel,
  input  logic [W-1:0] alu_z,
  input  logic         alu_cout,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [W-1:0] res_z,
  output logic         res_cout,
  output logic         res_zero,
  output logic         res_err,
  output logic [W-1:0] acc
);

`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = 1;
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = 1;

  typedef struct packed {
    logic [4:0]   sel;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         use_acc;
  } cmd_t;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    DONE
  } state_t;

  state_t        state;
  cmd_t          fifo [DEPTH];
  cmd_t          head;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [AW:0]   count_nxt;
  logic          push;
  logic          pop;
  logic          empty;
  logic          illegal;
  logic          cout_ok;
  logic [W-1:0]  issue_a;

  assign head    = fifo[rd_ptr];
  assign push    = cmd_valid && cmd_ready;
  assign pop     = (state == EXEC);
  assign empty   = (count == '0);
  assign illegal = (alu_sel >= 5'd9);
  assign cout_ok = (alu_sel >= 5'd2) && !illegal;
  assign issue_a = head.use_acc ? acc : head.a;

  always_comb begin
    count_nxt = count;
    unique case (1'b1)
      push && !pop: count_nxt = count + CNT_ONE;
      pop && !push: count_nxt = count - CNT_ONE;
      default:      count_nxt = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo[wr_ptr] <= {cmd_sel, cmd_a, cmd_b, cmd_use_acc};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      cmd_ready <= 1'b1;
      acc       <= '0;
      res_valid <= 1'b0;
      res_z     <= '0;
      res_cout  <= 1'b0;
      res_zero  <= 1'b0;
      res_err   <= 1'b0;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_sel   <= '0;
    end else begin
      count     <= count_nxt;
      // ready is pure registered state: a pop never reopens it same-cycle
      cmd_ready <= (count_nxt != CNT_FULL);
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      unique case (state)
        IDLE: begin
          if (!empty) begin
            state   <= EXEC;
            alu_a   <= issue_a;
            alu_b   <= head.b;
            alu_sel <= head.sel;
          end
        end
        EXEC: begin
          if (TRAP && illegal) begin
            res_z    <= '0;
            res_cout <= 1'b0;
            res_zero <= 1'b0;
            res_err  <= 1'b1;
          end else begin
            res_z    <= alu_z;
            res_cout <= cout_ok && alu_cout;
            res_zero <= (alu_z == '0);
            res_err  <= 1'b0;
            acc      <= alu_z;
          end
          res_valid <= 1'b1;
          alu_a     <= '0;
          alu_b     <= '0;
          alu_sel   <= '0;
          state     <= DONE;
        end
        DONE: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            if (!empty) begin
              state   <= EXEC;
              alu_a   <= issue_a;
              alu_b   <= head.b;
              alu_sel <= head.sel;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench for alu_cmd_sequencer with a behavioural ALU attached.
// Honours ALU_SEQ_ILLEGAL_TRAP_EN for the illegal-opcode expectations.
module tb_alu_cmd_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [4:0] cmd_sel = '0;
  logic [7:0] cmd_a = '0;
  logic [7:0] cmd_b = '0;
  logic       cmd_use_acc = 1'b0;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [4:0] alu_sel;
  logic [7:0] alu_z;
  logic       alu_cout;
  logic       res_valid;
  logic       res_ready = 1'b0;
  logic [7:0] res_z;
  logic       res_cout;
  logic       res_zero;
  logic       res_err;
  logic [7:0] acc;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  alu_cmd_sequencer #(.W(8), .DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_sel(cmd_sel), .cmd_a(cmd_a), .cmd_b(cmd_b),
    .cmd_use_acc(cmd_use_acc),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
    .alu_z(alu_z), .alu_cout(alu_cout),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_z(res_z), .res_cout(res_cout), .res_zero(res_zero),
    .res_err(res_err), .acc(acc)
  );

  // ALU model; Cout is junk (1) where the real ALU leaves it undriven
  always_comb begin
    alu_z    = '0;
    alu_cout = 1'b1;
    case (alu_sel)
      5'd0: alu_z = alu_a;
      5'd1: alu_z = alu_b;
      5'd2: begin alu_z = alu_a & alu_b; alu_cout = 1'b0; end
      5'd3: begin alu_z = alu_a | alu_b; alu_cout = 1'b0; end
      5'd4: {alu_cout, alu_z} = {1'b0, alu_a} - {1'b0, alu_b};
      5'd5: {alu_cout, alu_z} = {1'b0, alu_a} + {1'b0, alu_b};
      5'd6: {alu_cout, alu_z} = {1'b0, alu_a} + 9'd1;
      5'd7: {alu_cout, alu_z} = {1'b0, alu_a} + {1'b0, alu_b} + 9'd1;
      5'd8: {alu_cout, alu_z} = {1'b0, alu_a} - {1'b0, alu_b} - 9'd1;
      default: alu_z = '0;
    endcase
  end

  task automatic push(input logic [4:0] s, input logic [7:0] a,
                      input logic [7:0] b, input logic u);
    int t = 0;
    cmd_valid = 1'b1; cmd_sel = s; cmd_a = a; cmd_b = b; cmd_use_acc = u;
    while (!cmd_ready && t < 50) begin @(negedge clk); t++; end
    if (!cmd_ready) begin
      n_fail++;
      $display("FAIL push_timeout: cmd_ready=%b required 1", cmd_ready);
    end
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic get_res(output logic [7:0] z, output logic c,
                         output logic zr, output logic er, output logic to);
    int t = 0;
    while (!res_valid && t < 20) begin @(negedge clk); t++; end
    to = !res_valid;
    z = res_z; c = res_cout; zr = res_zero; er = res_err;
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    n_chk++;
    if ({cmd_ready, res_valid, res_z, res_cout, res_zero, res_err, acc}
        !== {1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00}) begin
      n_fail++;
      $display("FAIL reset_regs: rdy=%b v=%b z=%h c=%b zr=%b e=%b acc=%h",
               cmd_ready, res_valid, res_z, res_cout, res_zero, res_err, acc);
    end
    n_chk++;
    if ({alu_a, alu_b, alu_sel} !== 21'd0) begin
      n_fail++;
      $display("FAIL reset_alu: a=%h b=%h sel=%h required 0",
               alu_a, alu_b, alu_sel);
    end
  endtask

  task automatic test_latency();
    cmd_valid = 1'b1; cmd_sel = 5'd5; cmd_a = 8'h0F; cmd_b = 8'h01;
    cmd_use_acc = 1'b0;
    @(negedge clk);
    cmd_valid = 1'b0;
    n_chk++;
    if (res_valid !== 1'b0 || alu_sel !== 5'd0) begin
      n_fail++;
      $display("FAIL lat_n1: v=%b sel=%h required 0/00", res_valid, alu_sel);
    end
    @(negedge clk);
    n_chk++;
    if ({res_valid, alu_sel, alu_a, alu_b} !== {1'b0, 5'd5, 8'h0F, 8'h01}) begin
      n_fail++;
      $display("FAIL lat_exec: v=%b sel=%h a=%h b=%h required 0/05/0f/01",
               res_valid, alu_sel, alu_a, alu_b);
    end
    @(negedge clk);
    n_chk++;
    if ({res_valid, res_z, res_cout, res_zero, acc, alu_sel}
        !== {1'b1, 8'h10, 1'b0, 1'b0, 8'h10, 5'd0}) begin
      n_fail++;
      $display("FAIL lat_done: v=%b z=%h c=%b zr=%b acc=%h sel=%h",
               res_valid, res_z, res_cout, res_zero, acc, alu_sel);
    end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    n_chk++;
    if (res_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL lat_accept: v=%b required 0", res_valid);
    end
  endtask

  task automatic test_use_acc();
    logic [7:0] z; logic c, zr, er, to;
    push(5'd5, 8'hFF, 8'h01, 1'b0);
    push(5'd6, 8'h55, 8'h00, 1'b1);
    get_res(z, c, zr, er, to);
    n_chk++;
    if (to || {z, c, zr} !== {8'h00, 1'b1, 1'b1}) begin
      n_fail++;
      $display("FAIL acc_r1: to=%b z=%h c=%b zr=%b required 00/1/1",
               to, z, c, zr);
    end
    get_res(z, c, zr, er, to);
    n_chk++;
    if (to || {z, c, zr, acc} !== {8'h01, 1'b0, 1'b0, 8'h01}) begin
      n_fail++;
      $display("FAIL acc_r2: to=%b z=%h c=%b zr=%b acc=%h required 01/0/0/01",
               to, z, c, zr, acc);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] z; logic c, zr, er, to;
    for (int i = 0; i < 5; i++) push(5'd5, 8'(i), 8'h10, 1'b0);
    n_chk++;
    if (cmd_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL fifo_full: cmd_ready=%b required 0", cmd_ready);
    end
    repeat (3) @(negedge clk);
    n_chk++;
    if (res_valid !== 1'b1 || res_z !== 8'h10 || cmd_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_hold: v=%b z=%h rdy=%b required 1/10/0",
               res_valid, res_z, cmd_ready);
    end
    for (int i = 0; i < 5; i++) begin
      get_res(z, c, zr, er, to);
      n_chk++;
      if (to || z !== 8'h10 + 8'(i) || c !== 1'b0) begin
        n_fail++;
        $display("FAIL order_%0d: to=%b z=%h c=%b required %h/0",
                 i, to, z, c, 8'h10 + 8'(i));
      end
    end
    n_chk++;
    if (cmd_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL fifo_drain: cmd_ready=%b required 1", cmd_ready);
    end
  endtask

  task automatic test_ops();
    logic [4:0] ts [9] = '{5'd4, 5'd1, 5'd0, 5'd2, 5'd3,
                           5'd7, 5'd8, 5'd8, 5'd6};
    logic [7:0] ta [9] = '{8'h03, 8'h12, 8'h5A, 8'hF0, 8'hF0,
                           8'hFF, 8'h05, 8'h03, 8'hFF};
    logic [7:0] tb [9] = '{8'h05, 8'h77, 8'h33, 8'h3C, 8'h0C,
                           8'h00, 8'h03, 8'h03, 8'h00};
    logic [7:0] tz [9] = '{8'hFE, 8'h77, 8'h5A, 8'h30, 8'hFC,
                           8'h00, 8'h01, 8'hFF, 8'h00};
    logic       tc [9] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0,
                           1'b1, 1'b0, 1'b1, 1'b1};
    logic [7:0] z; logic c, zr, er, to;
    for (int i = 0; i < 9; i++) begin
      push(ts[i], ta[i], tb[i], 1'b0);
      get_res(z, c, zr, er, to);
      n_chk++;
      if (to || z !== tz[i] || c !== tc[i] || zr !== (tz[i] == 8'h00)
          || er !== 1'b0 || acc !== tz[i]) begin
        n_fail++;
        $display("FAIL op_sel%0d: to=%b z=%h c=%b zr=%b e=%b acc=%h req %h/%b",
                 ts[i], to, z, c, zr, er, acc, tz[i], tc[i]);
      end
    end
  endtask

  task automatic test_illegal();
    logic [7:0] z; logic c, zr, er, to;
    push(5'd0, 8'h22, 8'h00, 1'b0);
    get_res(z, c, zr, er, to);
    n_chk++;
    if (to || acc !== 8'h22) begin
      n_fail++;
      $display("FAIL ill_setup: to=%b acc=%h required 22", to, acc);
    end
    push(5'h1F, 8'h99, 8'h44, 1'b0);
    get_res(z, c, zr, er, to);
    n_chk++;
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
    if (to || {z, c, zr, er, acc} !== {8'h00, 1'b0, 1'b0, 1'b1, 8'h22}) begin
`else
    if (to || {z, c, zr, er, acc} !== {8'h00, 1'b0, 1'b1, 1'b0, 8'h00}) begin
`endif
      n_fail++;
      $display("FAIL ill_op: to=%b z=%h c=%b zr=%b e=%b acc=%h",
               to, z, c, zr, er, acc);
    end
    push(5'd6, 8'h40, 8'h00, 1'b0);
    get_res(z, c, zr, er, to);
    n_chk++;
    if (to || {z, er} !== {8'h41, 1'b0}) begin
      n_fail++;
      $display("FAIL ill_after: to=%b z=%h e=%b required 41/0", to, z, er);
    end
  endtask

  task automatic test_mid_reset();
    int t = 0;
    int seen = 0;
    push(5'd5, 8'h20, 8'h01, 1'b0);
    while (!res_valid && t < 20) begin @(negedge clk); t++; end
    push(5'd5, 8'h01, 8'h01, 1'b0);
    push(5'd5, 8'h02, 8'h02, 1'b0);
    n_chk++;
    if (res_valid !== 1'b1 || acc !== 8'h21) begin
      n_fail++;
      $display("FAIL mrst_pre: v=%b acc=%h required 1/21", res_valid, acc);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_chk++;
    if ({res_valid, acc, cmd_ready, res_z} !== {1'b0, 8'h00, 1'b1, 8'h00}) begin
      n_fail++;
      $display("FAIL mrst_post: v=%b acc=%h rdy=%b z=%h required 0/00/1/00",
               res_valid, acc, cmd_ready, res_z);
    end
    res_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (res_valid || alu_sel != 5'd0) seen++;
    end
    res_ready = 1'b0;
    n_chk++;
    if (seen != 0) begin
      n_fail++;
      $display("FAIL mrst_flush: %0d active cycles required 0", seen);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_latency();
    test_use_acc();
    test_back_to_back();
    test_ops();
    test_illegal();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
